mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the core's instruction-fetch and data ports. It arbitrates both
//  ports onto one single-ported external memory bus with a req/ack handshake.
//  It produces the fetch-valid and data-ready strobes that the pipeline hazard unit uses to
//  stall the FETCH and EXEC stages. Data has priority over fetch, so a data stall cannot
//  starve behind a fetch.
// PARAMETERS
//  AW       32  address width (bits)
//  DW       32  data width (bits); DW/8 byte strobes
//  TIMEOUT  16  cycles without mem_ack before the transaction aborts with bus_err (>=2)
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     asynchronous active-low reset
//  i_req      in   1     fetch request; held with i_addr until i_valid
//  i_addr     in   AW    fetch address
//  i_kill     in   1     fetch redirect (branch/jump); drops the in-flight fetch result
//  i_rdata    out  DW    fetch data; valid while i_valid
//  i_valid    out  1     1-cycle fetch-complete strobe (drives FETCH_valid)
//  d_req      in   1     data request; d_we/d_addr/d_wdata/d_wstrb held until d_valid
//  d_we       in   1     1=store, 0=load
//  d_addr     in   AW    data address
//  d_wdata    in   DW    store data
//  d_wstrb    in   DW/8  store byte enables
//  d_rdata    out  DW    load data; valid while d_valid
//  d_valid    out  1     1-cycle data-complete strobe
//  d_ready    out  1     ~d_req | d_valid, combinational (drives MEM_valid)
//  mem_req    out  1     external bus request
//  mem_we     out  1     external write enable
//  mem_addr   out  AW    external address
//  mem_wdata  out  DW    external write data
//  mem_wstrb  out  DW/8  external byte enables
//  mem_rdata  in   DW    external read data; sampled on mem_ack
//  mem_ack    in   1     external completion; may come in the first mem_req cycle
//  bus_err    out  1     1-cycle strobe, coincident with the valid of a timed-out transaction
// BEHAVIOUR
//  Reset: state=IDLE. mem_req, mem_we, i_valid, d_valid and bus_err are 0. mem_addr,
//   mem_wdata, mem_wstrb, i_rdata and d_rdata are 0. Reset mid-transaction abandons it; no
//   valid is issued.
//  FSM IDLE -> {DBUS | IBUS} -> RESP -> IDLE.
//  IDLE: d_req=1 latches d_* and goes to DBUS. Otherwise i_req=1 latches i_addr and goes to
//   IBUS. Otherwise stays in IDLE. Inputs are sampled only in IDLE.
//  DBUS/IBUS: mem_req=1; mem_* are driven from the latched registers and stay stable. mem_we
//   is 0 in IBUS. A wait counter clears on entry and increments each cycle without ack.
//   - mem_ack=1: capture mem_rdata and go to RESP.
//   - Counter reaches TIMEOUT-1 without ack: go to RESP with err set and rdata=0.
//  RESP (exactly 1 cycle): mem_req=0. The matching valid=1 and rdata is held.
//   bus_err=err. No new request is accepted, so the requester can update its req/addr on
//   this edge.
//  Latency: req in IDLE at cycle 0, ack in cycle 1 -> valid in cycle 2. Each extra wait
//   cycle adds 1.
//  i_kill while in IBUS, or in the cycle the fetch is latched: the bus transaction still
//   completes, and a kill flag is set. In RESP, i_valid is forced to 0 and the result is
//   discarded. i_kill in IDLE or RESP has no effect. i_kill never affects DBUS.
//  d_req and i_req both high in IDLE: data wins. Fetch is served on the next IDLE if i_req
//   is still high.
//  Stores complete like loads. d_rdata is don't-care on a store but still registered from
//   mem_rdata.
//  The wait counter saturates and never wraps. Width is clog2(TIMEOUT).
//  Writes are never issued in IBUS. mem_wstrb=0 in IBUS.
// TESTING
//  1. i_req=1, i_addr=0x100, mem_ack in first req cycle, mem_rdata=0x00000013 -> mem_req
//     high cycle 1; i_valid=1, i_rdata=0x13 in cycle 2.
//  2. d_req and i_req rise together (load 0x2000) -> DBUS first; d_valid precedes i_valid;
//     fetch mem_addr appears only after RESP.
//  3. Store d_addr=0x40, d_wdata=0xDEADBEEF, d_wstrb=4'b0011, ack after 3 waits ->
//     mem_we=1, mem_wstrb=0011 held 4 cycles; d_valid 1 cycle later; d_ready low until then.
//  4. i_kill pulsed in the 2nd IBUS cycle, ack 2 cycles later -> no i_valid; next fetch
//     issues normally.
//  5. No mem_ack, TIMEOUT=16 -> mem_req high exactly 16 cycles; then d_valid=1, bus_err=1,
//     d_rdata=0.
//  6. rst_n low while in DBUS -> all outputs 0 immediately (async); after release, state is
//     IDLE and the held request is restarted cleanly.

Source files
------------

// File: rtl/mem_responder_if.sv
// mem_responder_if: core fetch/data ports plus external memory bus of the responder
interface mem_responder_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              i_req;
    logic [AW-1:0]     i_addr;
    logic              i_kill;
    logic [DW-1:0]     i_rdata;
    logic              i_valid;
    logic              d_req;
    logic              d_we;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic [DW/8-1:0]   d_wstrb;
    logic [DW-1:0]     d_rdata;
    logic              d_valid;
    logic              d_ready;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_wstrb;
    logic [DW-1:0]     mem_rdata;
    logic              mem_ack;
    logic              bus_err;

    modport slave (
        input  i_req, i_addr, i_kill, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ack,
        output i_rdata, i_valid, d_rdata, d_valid, d_ready,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, bus_err
    );

    modport master (
        output i_req, i_addr, i_kill, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ack,
        input  i_rdata, i_valid, d_rdata, d_valid, d_ready,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, bus_err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: arbitrates fetch and data ports onto one req/ack memory bus, data first
module mem_responder #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_responder_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DBUS, IBUS, RESP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              kill_q, kill_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic [DW/8-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [DW-1:0]     i_rdata_q, i_rdata_d;
    logic              i_valid_q, i_valid_d;
    logic [DW-1:0]     d_rdata_q, d_rdata_d;
    logic              d_valid_q, d_valid_d;
    logic              bus_err_q, bus_err_d;
    logic              done, killed;

    assign done   = bus.mem_ack || cnt_q == CW'(TIMEOUT - 1);
    assign killed = kill_q || bus.i_kill;

    // Next-state: latch requests in IDLE, wait for ack or timeout, strobe results in RESP
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        kill_d      = kill_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_valid_d   = 1'b0;
        d_valid_d   = 1'b0;
        bus_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.d_req) begin
                    state_d     = DBUS;
                    cnt_d       = '0;
                    kill_d      = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_wstrb_d = bus.d_wstrb;
                end else if (bus.i_req) begin
                    state_d     = IBUS;
                    cnt_d       = '0;
                    kill_d      = bus.i_kill;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.i_addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                end
            end
            DBUS: begin
                if (done) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_valid_d = 1'b1;
                    bus_err_d = ~bus.mem_ack;
                    d_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
                end else begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
                end
            end
            IBUS: begin
                kill_d = killed;
                if (done) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    i_valid_d = ~killed;
                    bus_err_d = ~bus.mem_ack & ~killed;
                    i_rdata_d = killed ? i_rdata_q : (bus.mem_ack ? bus.mem_rdata : '0);
                end else begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; async reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            kill_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            i_rdata_q   <= '0;
            i_valid_q   <= 1'b0;
            d_rdata_q   <= '0;
            d_valid_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            kill_q      <= kill_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            i_rdata_q   <= i_rdata_d;
            i_valid_q   <= i_valid_d;
            d_rdata_q   <= d_rdata_d;
            d_valid_q   <= d_valid_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_valid   = i_valid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.d_ready   = ~bus.d_req | d_valid_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven transactions plus directed priority, kill and reset sequences
module tb_mem_responder;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_responder_if #(.AW(32), .DW(32)) bus ();

    mem_responder #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          waits;
        logic [31:0] mem_rd;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // {is_d, we, addr, wdata, wstrb, waits, mem_rdata, exp_we, exp_wstrb, exp_rdata, exp_err, exp_cycles}
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         4'h0, 0,  32'h0000_0013, 1'b0, 4'h0, 32'h0000_0013, 1'b0, 1};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         4'h0, 1,  32'hCAFE_F00D, 1'b0, 4'h0, 32'hCAFE_F00D, 1'b0, 2};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'h3, 3,  32'h0000_0055, 1'b1, 4'h3, 32'h0000_0055, 1'b0, 4};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,         4'h0, 99, 32'h1234_5678, 1'b0, 4'h0, 32'h0000_0000, 1'b1, 16};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0,         4'h0, 99, 32'h8765_4321, 1'b0, 4'h0, 32'h0000_0000, 1'b1, 16};
        vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 14, 32'h0BAD_CAFE, 1'b0, 4'h0, 32'h0BAD_CAFE, 1'b0, 15};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0ACC, 32'h0,         4'h0, 15, 32'h5A5A_A5A5, 1'b0, 4'h0, 32'h5A5A_A5A5, 1'b0, 16};

        rst_n         = 1'b0;
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.i_kill    = 1'b0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.d_wstrb   = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ctrl", 32'({bus.mem_req, bus.mem_we, bus.i_valid, bus.d_valid, bus.bus_err}), 32'h0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chk("rst_wstrb", 32'(bus.mem_wstrb), 32'h0);
        chk("rst_rdata", bus.i_rdata | bus.d_rdata, 32'h0);
        chk("rst_d_ready", 32'(bus.d_ready), 32'h1);

        for (int k = 0; k < 7; k++) begin
            vec_t v;
            int   n;
            int   lat;
            bit   seen;
            v    = vecs[k];
            n    = 0;
            lat  = 0;
            seen = 1'b0;
            bus.d_req     = v.is_d;
            bus.i_req     = ~v.is_d;
            bus.d_we      = v.is_d ? v.we : 1'b1;
            bus.d_addr    = v.addr;
            bus.i_addr    = v.addr;
            bus.d_wdata   = v.wdata;
            bus.d_wstrb   = v.is_d ? v.wstrb : 4'hF;
            bus.mem_rdata = v.mem_rd;
            for (int c = 0; c < 40 && !seen; c++) begin
                @(negedge clk);
                if (bus.i_valid || bus.d_valid) begin
                    seen = 1'b1;
                    lat  = c;
                    chk($sformatf("v%0d_valid_sel", k), 32'({bus.d_valid, bus.i_valid}), v.is_d ? 32'h2 : 32'h1);
                    chk($sformatf("v%0d_rdata", k), v.is_d ? bus.d_rdata : bus.i_rdata, v.exp_rdata);
                    chk($sformatf("v%0d_bus_err", k), 32'(bus.bus_err), 32'(v.exp_err));
                    chk($sformatf("v%0d_req_in_resp", k), 32'(bus.mem_req), 32'h0);
                    if (v.is_d) chk($sformatf("v%0d_d_ready_valid", k), 32'(bus.d_ready), 32'h1);
                    bus.mem_ack = 1'b0;
                    bus.d_req   = 1'b0;
                    bus.i_req   = 1'b0;
                end else if (bus.mem_req) begin
                    if (n == 0) begin
                        chk($sformatf("v%0d_addr", k), bus.mem_addr, v.addr);
                        chk($sformatf("v%0d_we", k), 32'(bus.mem_we), 32'(v.exp_we));
                        chk($sformatf("v%0d_wstrb", k), 32'(bus.mem_wstrb), 32'(v.exp_wstrb));
                        if (v.is_d) begin
                            chk($sformatf("v%0d_wdata", k), bus.mem_wdata, v.wdata);
                            chk($sformatf("v%0d_d_ready_wait", k), 32'(bus.d_ready), 32'h0);
                        end
                    end
                    n++;
                    bus.mem_ack = (n - 1 == v.waits);
                end
            end
            chk($sformatf("v%0d_valid_seen", k), 32'(seen), 32'h1);
            chk($sformatf("v%0d_bus_cycles", k), 32'(n), 32'(v.exp_cycles));
            chk($sformatf("v%0d_latency", k), 32'(lat), 32'(v.exp_cycles));
            @(negedge clk);
            chk($sformatf("v%0d_strobe_1cyc", k), 32'({bus.i_valid, bus.d_valid, bus.bus_err}), 32'h0);
        end

        // data and fetch requested together: data served first, fetch after RESP
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h0000_2000;
        bus.d_wstrb   = 4'h0;
        bus.i_req     = 1'b1;
        bus.i_addr    = 32'h0000_0100;
        bus.mem_rdata = 32'hAAAA_5555;
        @(negedge clk);
        chk("prio_first_addr", bus.mem_addr, 32'h0000_2000);
        chk("prio_first_req", 32'(bus.mem_req), 32'h1);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        chk("prio_dvalid_first", 32'({bus.d_valid, bus.i_valid}), 32'h2);
        chk("prio_drdata", bus.d_rdata, 32'hAAAA_5555);
        bus.mem_ack   = 1'b0;
        bus.d_req     = 1'b0;
        bus.mem_rdata = 32'h0000_0013;
        @(negedge clk);
        chk("prio_idle_gap", 32'(bus.mem_req), 32'h0);
        @(negedge clk);
        chk("prio_fetch_req", 32'(bus.mem_req), 32'h1);
        chk("prio_fetch_addr", bus.mem_addr, 32'h0000_0100);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        chk("prio_ivalid", 32'({bus.d_valid, bus.i_valid}), 32'h1);
        chk("prio_irdata", bus.i_rdata, 32'h0000_0013);
        bus.mem_ack = 1'b0;
        bus.i_req   = 1'b0;
        @(negedge clk);

        // kill in the second IBUS cycle: bus completes, result dropped, redirected fetch follows
        bus.i_req     = 1'b1;
        bus.i_addr    = 32'h0000_0300;
        bus.mem_rdata = 32'h0000_0077;
        @(negedge clk);
        chk("kill_req_c1", 32'(bus.mem_req), 32'h1);
        @(negedge clk);
        bus.i_kill = 1'b1;
        bus.i_addr = 32'h0000_0400;
        @(negedge clk);
        bus.i_kill = 1'b0;
        chk("kill_addr_stable", bus.mem_addr, 32'h0000_0300);
        @(negedge clk);
        chk("kill_req_c4", 32'(bus.mem_req), 32'h1);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        chk("kill_no_ivalid", 32'(bus.i_valid), 32'h0);
        chk("kill_req_resp", 32'(bus.mem_req), 32'h0);
        chk("kill_no_err", 32'(bus.bus_err), 32'h0);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0000_0099;
        @(negedge clk);
        @(negedge clk);
        chk("kill_next_addr", bus.mem_addr, 32'h0000_0400);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        chk("kill_next_ivalid", 32'(bus.i_valid), 32'h1);
        chk("kill_next_rdata", bus.i_rdata, 32'h0000_0099);
        bus.mem_ack = 1'b0;
        bus.i_req   = 1'b0;
        @(negedge clk);

        // async reset while in DBUS, then the held store restarts cleanly
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b1;
        bus.d_addr    = 32'h0000_0500;
        bus.d_wdata   = 32'h1122_3344;
        bus.d_wstrb   = 4'hF;
        bus.mem_rdata = 32'h0;
        @(negedge clk);
        chk("rstmid_req_before", 32'(bus.mem_req), 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_ctrl", 32'({bus.mem_req, bus.mem_we, bus.d_valid, bus.i_valid, bus.bus_err}), 32'h0);
        chk("rstmid_addr", bus.mem_addr, 32'h0);
        chk("rstmid_wdata", bus.mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_restart_req", 32'(bus.mem_req), 32'h1);
        chk("rstmid_restart_addr", bus.mem_addr, 32'h0000_0500);
        chk("rstmid_restart_we", 32'(bus.mem_we), 32'h1);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        chk("rstmid_dvalid", 32'(bus.d_valid), 32'h1);
        chk("rstmid_no_err", 32'(bus.bus_err), 32'h0);
        bus.mem_ack = 1'b0;
        bus.d_req   = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
